// File: rtl/mdio_pkg.sv
// Shared constants, FSM encoding and helpers for the Clause-22 MDIO PHY responder.
package mdio_pkg;

  localparam logic [1:0] OP_READ      = 2'b10;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] ST_BITS      = 2'b01;
  localparam int         PREAMBLE_LEN = 32;

  localparam logic [4:0] REG_PHYID1 = 5'd2;
  localparam logic [4:0] REG_PHYID2 = 5'd3;

  typedef enum logic [2:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA
  } mdio_state_e;

  function automatic logic is_id_reg(input logic [4:0] addr);
    return (addr == REG_PHYID1) || (addr == REG_PHYID2);
  endfunction

endpackage

// File: rtl/mdio_phy_regfile.sv
// 32x16 PHY register file: ID registers 2/3 are constants, host writes land one cycle
// after the strobe, and an MDIO commit beats a host write to the same register.
module mdio_phy_regfile
  import mdio_pkg::*;
#(
  parameter logic [15:0] PHY_ID_HI = 16'h0000,
  parameter logic [15:0] PHY_ID_LO = 16'h0000
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mdio_we,
  input  logic [4:0]  mdio_waddr,
  input  logic [15:0] mdio_wdata,
  input  logic [4:0]  mdio_raddr,
  output logic [15:0] mdio_rdata,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata
);

  logic        host_we_q, host_we_d;
  logic [4:0]  host_addr_q, host_addr_d;
  logic [15:0] host_wdata_q, host_wdata_d;
  logic [31:0][15:0] mem_flat;

  always_comb begin
    host_we_d    = host_we;
    host_addr_d  = host_addr;
    host_wdata_d = host_wdata;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      host_we_q    <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
    end else begin
      host_we_q    <= host_we_d;
      host_addr_q  <= host_addr_d;
      host_wdata_q <= host_wdata_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      logic [15:0] word_q, word_d;

      // MDIO assignment comes last so it overrides a coincident host write.
      always_comb begin
        word_d = word_q;
        if (!is_id_reg(5'(gi))) begin
          if (host_we_q && (host_addr_q == 5'(gi))) word_d = host_wdata_q;
          if (mdio_we && (mdio_waddr == 5'(gi)))    word_d = mdio_wdata;
        end
      end

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) word_q <= '0;
        else         word_q <= word_d;
      end

      assign mem_flat[gi] = word_q;
    end
  endgenerate

  function automatic logic [15:0] rd_word(input logic [4:0] addr);
    if (addr == REG_PHYID1)      return PHY_ID_HI;
    else if (addr == REG_PHYID2) return PHY_ID_LO;
    else                         return mem_flat[addr];
  endfunction

  always_comb begin
    mdio_rdata = rd_word(mdio_raddr);
    host_rdata = rd_word(host_addr);
  end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO, decodes frames, serves reads and commits writes.
// Build option MDIO_RESPONDER_BCAST_EN: also accept PHYAD 0 for write frames.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [15:0] PHY_ID_HI   = 16'h0000,
  parameter logic [15:0] PHY_ID_LO   = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        upd_valid,
  output logic [4:0]  upd_addr,
  output logic [15:0] upd_data
);

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
  logic                   mdc_prev_q, mdc_prev_d;

  mdio_state_e state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        is_read_q, is_read_d;
  logic [15:0] sh_q, sh_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        upd_valid_q, upd_valid_d;
  logic [4:0]  upd_addr_q, upd_addr_d;
  logic [15:0] upd_data_q, upd_data_d;
  logic        arm_q, arm_d;
  logic        oe_q, oe_d;
  logic        o_q, o_d;
  logic [15:0] drv_sh_q, drv_sh_d;
  logic [4:0]  drv_cnt_q, drv_cnt_d;

  logic        mdc_s, mdio_s, rise, fall, addr_ok;
  logic [15:0] in_sh, mdio_rdata;

  assign mdc_s  = mdc_sync_q[SYNC_STAGES-1];
  assign mdio_s = mdio_sync_q[SYNC_STAGES-1];
  assign rise   = mdc_s & ~mdc_prev_q;
  assign fall   = ~mdc_s & mdc_prev_q;
  assign in_sh  = {sh_q[14:0], mdio_s};

  always_comb begin
    mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
    mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
    mdc_prev_d  = mdc_s;
  end

  // Broadcast address is write-only; is_read_q is already known when PHYAD completes.
  always_comb begin
    addr_ok = (in_sh[4:0] == PHY_ADDR);
`ifdef MDIO_RESPONDER_BCAST_EN
    if (!is_read_q && (in_sh[4:0] == 5'd0)) addr_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    is_read_d   = is_read_q;
    sh_d        = sh_q;
    regad_d     = regad_q;
    rd_data_d   = rd_data_q;
    upd_valid_d = 1'b0;
    upd_addr_d  = upd_addr_q;
    upd_data_d  = upd_data_q;
    arm_d       = arm_q;
    oe_d        = oe_q;
    o_d         = o_q;
    drv_sh_d    = drv_sh_q;
    drv_cnt_d   = drv_cnt_q;

    if (rise) begin
      unique case (state_q)
        IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q != 6'(PREAMBLE_LEN)) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            if ((pre_cnt_q == 6'(PREAMBLE_LEN)) && (mdio_s == ST_BITS[1])) state_d = ST;
            pre_cnt_d = '0;
          end
        end
        ST: begin
          bit_cnt_d = '0;
          state_d   = (mdio_s == ST_BITS[0]) ? OP : IDLE;
        end
        OP: begin
          sh_d = in_sh;
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (in_sh[1:0] == OP_READ) begin
              is_read_d = 1'b1;
              state_d   = PHYAD;
            end else if (in_sh[1:0] == OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = PHYAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        PHYAD: begin
          sh_d = in_sh;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = addr_ok ? REGAD : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        REGAD: begin
          sh_d = in_sh;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            regad_d   = in_sh[4:0];
            rd_data_d = mdio_rdata;
            state_d   = TA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        TA: begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
            if (!is_read_q && !mdio_s) state_d = IDLE;
          end else begin
            bit_cnt_d = '0;
            if (is_read_q) begin
              arm_d   = 1'b1;
              state_d = DATA;
            end else begin
              state_d = mdio_s ? IDLE : DATA;
            end
          end
        end
        DATA: begin
          sh_d = in_sh;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            if (!is_read_q && !is_id_reg(regad_q)) begin
              upd_valid_d = 1'b1;
              upd_addr_d  = regad_q;
              upd_data_d  = in_sh;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d == IDLE && state_q != IDLE) pre_cnt_d = '0;
    end

    // Read driver runs on its own falls: turnaround 0, sixteen data bits, then release.
    if (fall) begin
      if (arm_q) begin
        arm_d     = 1'b0;
        oe_d      = 1'b1;
        o_d       = 1'b0;
        drv_sh_d  = rd_data_q;
        drv_cnt_d = 5'd16;
      end else if (oe_q && (drv_cnt_q != 5'd0)) begin
        o_d       = drv_sh_q[15];
        drv_sh_d  = {drv_sh_q[14:0], 1'b0};
        drv_cnt_d = drv_cnt_q - 5'd1;
      end else if (oe_q) begin
        oe_d = 1'b0;
        o_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      is_read_q   <= 1'b0;
      sh_q        <= '0;
      regad_q     <= '0;
      rd_data_q   <= '0;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      upd_data_q  <= '0;
      arm_q       <= 1'b0;
      oe_q        <= 1'b0;
      o_q         <= 1'b0;
      drv_sh_q    <= '0;
      drv_cnt_q   <= '0;
    end else begin
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      is_read_q   <= is_read_d;
      sh_q        <= sh_d;
      regad_q     <= regad_d;
      rd_data_q   <= rd_data_d;
      upd_valid_q <= upd_valid_d;
      upd_addr_q  <= upd_addr_d;
      upd_data_q  <= upd_data_d;
      arm_q       <= arm_d;
      oe_q        <= oe_d;
      o_q         <= o_d;
      drv_sh_q    <= drv_sh_d;
      drv_cnt_q   <= drv_cnt_d;
    end
  end

  mdio_phy_regfile #(
    .PHY_ID_HI(PHY_ID_HI),
    .PHY_ID_LO(PHY_ID_LO)
  ) u_regfile (
    .clk       (clk),
    .arst_n    (arst_n),
    .mdio_we   (upd_valid_q),
    .mdio_waddr(upd_addr_q),
    .mdio_wdata(upd_data_q),
    .mdio_raddr(in_sh[4:0]),
    .mdio_rdata(mdio_rdata),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  assign mdio_o    = o_q;
  assign mdio_oe   = oe_q;
  assign upd_valid = upd_valid_q;
  assign upd_addr  = upd_addr_q;
  assign upd_data  = upd_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench: frames push expected driven bits / commits; monitors pop and compare.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        mdc_i = 1'b0;
  logic        mdio_i = 1'b1;
  logic        mdio_o, mdio_oe;
  logic        host_we = 1'b0;
  logic [4:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        upd_valid;
  logic [4:0]  upd_addr;
  logic [15:0] upd_data;

  int checks = 0;
  int failures = 0;

  logic        drv_q[$];
  logic [20:0] upd_q[$];

  mdio_phy_responder #(
    .PHY_ADDR   (5'd1),
    .PHY_ID_HI  (16'h0141),
    .PHY_ID_LO  (16'h1234),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .mdc_i     (mdc_i),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .upd_valid (upd_valid),
    .upd_addr  (upd_addr),
    .upd_data  (upd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: the master samples on MDC rise, so that is when a driven bit is judged.
  initial begin
    forever begin
      @(posedge mdc_i);
      if (mdio_oe === 1'b1) begin
        checks++;
        if (drv_q.size() == 0) begin
          failures++;
          $display("FAIL drive_unexpected actual=oe1 o=%0b required=released", mdio_o);
        end else begin
          logic e;
          e = drv_q.pop_front();
          if (mdio_o !== e) begin
            failures++;
            $display("FAIL drive_bit actual=%0b required=%0b", mdio_o, e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (upd_valid === 1'b1) begin
        checks++;
        if (upd_q.size() == 0) begin
          failures++;
          $display("FAIL upd_unexpected actual=addr%0d data=0x%h required=none", upd_addr, upd_data);
        end else begin
          logic [20:0] e;
          e = upd_q.pop_front();
          if ({upd_addr, upd_data} !== e) begin
            failures++;
            $display("FAIL upd_commit actual=0x%h required=0x%h", {upd_addr, upd_data}, e);
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic mdc_bit(input logic b);
    mdio_i = b;
    #100 mdc_i = 1'b1;
    #100 mdc_i = 1'b0;
  endtask

  task automatic push_read(input logic [15:0] d);
    drv_q.push_back(1'b0);
    for (int i = 15; i >= 0; i--) drv_q.push_back(d[i]);
  endtask

  // abort_at >= 0: assert arst_n after that many DATA bits of the frame.
  task automatic frame(input string name, input int pre, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] rg, input logic [1:0] ta,
                       input logic [15:0] wd, input int abort_at);
    repeat (pre) mdc_bit(1'b1);
    mdc_bit(1'b0);
    mdc_bit(1'b1);
    for (int i = 1; i >= 0; i--) mdc_bit(op[i]);
    for (int i = 4; i >= 0; i--) mdc_bit(phy[i]);
    for (int i = 4; i >= 0; i--) mdc_bit(rg[i]);
    for (int i = 1; i >= 0; i--) mdc_bit(ta[i]);
    for (int i = 15; i >= 0; i--) begin
      if (15 - i == abort_at) begin
        #20;
        check("oe_before_rst", 32'(mdio_oe), 32'd1);
        arst_n = 1'b0;
        #1;
        check("oe_async_rst", 32'(mdio_oe), 32'd0);
        drv_q.delete();
        #50 arst_n = 1'b1;
        #100;
        $display("frame %0s aborted by reset", name);
        return;
      end
      mdc_bit(wd[i]);
    end
    mdc_bit(1'b1);
    mdc_bit(1'b1);
    #100;
    $display("frame %0s done", name);
  endtask

  task automatic rd(input string name, input int pre, input logic [4:0] phy, input logic [4:0] rg);
    frame(name, pre, 2'b10, phy, rg, 2'b11, 16'hFFFF, -1);
  endtask

  task automatic wr(input string name, input int pre, input logic [4:0] phy, input logic [4:0] rg,
                    input logic [1:0] ta, input logic [15:0] d);
    frame(name, pre, 2'b01, phy, rg, ta, d, -1);
  endtask

  task automatic drained(input string name);
    check({name, "_drv_left"}, 32'(drv_q.size()), 32'd0);
    check({name, "_upd_left"}, 32'(upd_q.size()), 32'd0);
  endtask

  task automatic host_read(input string name, input logic [4:0] a, input logic [15:0] exp);
    @(negedge clk);
    host_addr = a;
    #1 check(name, 32'(host_rdata), 32'(exp));
  endtask

  task automatic host_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    @(negedge clk);
    $display("host write reg%0d=0x%h", a, d);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_oe", 32'(mdio_oe), 32'd0);
    check("rst_o", 32'(mdio_o), 32'd0);
    check("rst_upd_valid", 32'(upd_valid), 32'd0);
    check("rst_upd_addr", 32'(upd_addr), 32'd0);
    check("rst_upd_data", 32'(upd_data), 32'd0);
    host_read("rst_reg0", 5'd0, 16'h0000);
    host_read("rst_reg2", 5'd2, 16'h0141);
    host_read("rst_reg3", 5'd3, 16'h1234);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Read PHY ID high.
    push_read(16'h0141);
    rd("read_id_hi", 32, 5'd1, 5'd2);
    drained("read_id_hi");

    // Write then read back reg 0.
    upd_q.push_back({5'd0, 16'hA5C3});
    wr("write_r0", 32, 5'd1, 5'd0, 2'b10, 16'hA5C3);
    push_read(16'hA5C3);
    rd("read_r0", 32, 5'd1, 5'd0);
    drained("write_read_r0");
    host_read("host_r0", 5'd0, 16'hA5C3);

    // Other PHY address: ignored, then a valid frame still decodes.
    wr("write_phy5", 32, 5'd5, 5'd0, 2'b10, 16'h1111);
    rd("read_phy5", 32, 5'd5, 5'd0);
    push_read(16'hA5C3);
    rd("read_after_phy5", 32, 5'd1, 5'd0);
    drained("phy5");

    // Short preamble ignored, long preamble accepted.
    mdc_bit(1'b0);
    wr("short_pre", 31, 5'd1, 5'd4, 2'b10, 16'h1111);
    upd_q.push_back({5'd4, 16'hBEEF});
    wr("long_pre", 40, 5'd1, 5'd4, 2'b10, 16'hBEEF);
    drained("preamble");
    host_read("host_r4", 5'd4, 16'hBEEF);

    // Bad turnaround and write to a read-only ID register.
    wr("bad_ta", 32, 5'd1, 5'd5, 2'b00, 16'h0F0F);
    host_read("host_r5", 5'd5, 16'h0000);
    wr("write_id_lo", 32, 5'd1, 5'd3, 2'b10, 16'hFFFF);
    host_read("host_r3", 5'd3, 16'h1234);
    push_read(16'h1234);
    rd("read_id_lo", 32, 5'd1, 5'd3);
    drained("no_commit");

    // Host port: normal register and ignored ID register.
    host_write(5'd6, 16'h5A5A);
    host_read("host_r6", 5'd6, 16'h5A5A);
    host_write(5'd2, 16'hDEAD);
    host_read("host_r2", 5'd2, 16'h0141);
    push_read(16'h5A5A);
    rd("read_r6", 32, 5'd1, 5'd6);
    drained("host");

    // Reset in the middle of a read, then a clean read.
    push_read(16'hA5C3);
    frame("read_rst", 32, 2'b10, 5'd1, 5'd0, 2'b11, 16'hFFFF, 7);
    host_read("post_rst_r0", 5'd0, 16'h0000);
    push_read(16'h0141);
    rd("read_after_rst", 32, 5'd1, 5'd2);
    drained("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
